ysyx_20020207_lsu: RTL

//  Load/store unit directly downstream of the ALU. Captures the ALU-computed lsu_addr on addr_valid,

---
 rtl/ysyx_20020207_lsu_pkg.sv | 33 +++
 rtl/ysyx_20020207_lsu_align.sv | 45 ++++
 rtl/ysyx_20020207_lsu.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ysyx_20020207_lsu_pkg.sv
// Shared types and constants for the ysyx_20020207 load/store unit.
// Holds the FSM encoding, funct3 decode values, error codes and request legality check.
package ysyx_20020207_lsu_pkg;

  typedef enum logic [2:0] {StIdle, StAr, StR, StWr, StB, StDone} lsu_state_e;

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3Bu = 3'b100;
  localparam logic [2:0] F3Hu = 3'b101;

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrBus      = 2'b10;
  localparam logic [1:0] ErrIllegal  = 2'b11;

  localparam logic [1:0] RespOkay = 2'b00;

  // Illegal op takes priority over misalignment; unsigned widths are load-only.
  function automatic logic [1:0] req_check(input logic is_store, input logic [2:0] op,
                                           input logic [1:0] addr_lo);
    logic [1:0] err;
    err = ErrOk;
    if (op == 3'b011 || op == 3'b110 || op == 3'b111 || (is_store && op[2])) begin
      err = ErrIllegal;
    end else if ((op[1:0] == 2'b01 && addr_lo[0]) || (op == F3W && addr_lo != 2'b00)) begin
      err = ErrMisalign;
    end
    return err;
  endfunction

endpackage

// File: rtl/ysyx_20020207_lsu_align.sv
// Byte-lane steering for the load/store unit: store strobe/data replication and
// load lane select with sign or zero extension.
module ysyx_20020207_lsu_align
  import ysyx_20020207_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (op[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane = bus_rdata >> {addr_lo, 3'b000};
    case (op)
      F3B:     load_data = {{24{lane[7]}}, lane[7:0]};
      F3H:     load_data = {{16{lane[15]}}, lane[15:0]};
      F3W:     load_data = lane;
      F3Bu:    load_data = {24'h0, lane[7:0]};
      F3Hu:    load_data = {16'h0, lane[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_20020207_lsu.sv
// Load/store unit: captures one request from the ALU, runs a single AXI4-Lite read or
// write, and returns aligned load data or a fault code with a one-cycle lsu_valid.
module ysyx_20020207_lsu
  import ysyx_20020207_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [2:0]        mem_op,
  input  logic [31:0]       store_data,
  output logic              lsu_busy,
  output logic              lsu_valid,
  output logic [31:0]       lsu_rdata,
  output logic [1:0]        lsu_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  lsu_state_e  state_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  op_q;
  logic [31:0] data_q;
  logic        aw_done_q, w_done_q;
  logic [31:0] load_data;
  logic [1:0]  req_err;
  logic        aw_fire, w_fire, aw_done_d, w_done_d;

  assign req_err   = req_check(mem_wen, mem_op, lsu_addr[1:0]);
  assign aw_fire   = awvalid & awready;
  assign w_fire    = wvalid & wready;
  assign aw_done_d = aw_done_q | aw_fire;
  assign w_done_d  = w_done_q | w_fire;

  // Lane logic works only off latched request state, so bus payload never sees addr_valid.
  ysyx_20020207_lsu_align u_align (
    .op         (op_q),
    .addr_lo    (addr_lo_q),
    .store_data (data_q),
    .bus_rdata  (rdata),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .load_data  (load_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_lo_q <= 2'b00;
      op_q      <= 3'b000;
      data_q    <= 32'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      lsu_busy  <= 1'b0;
      lsu_valid <= 1'b0;
      lsu_rdata <= 32'h0;
      lsu_err   <= ErrOk;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      lsu_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (addr_valid && (mem_ren || mem_wen)) begin
            addr_lo_q <= lsu_addr[1:0];
            op_q      <= mem_op;
            data_q    <= store_data;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            lsu_rdata <= 32'h0;
            lsu_err   <= req_err;
            if (req_err != ErrOk) begin
              state_q   <= StDone;
              lsu_valid <= 1'b1;
            end else if (mem_wen) begin
              state_q  <= StWr;
              awaddr   <= lsu_addr;
              awvalid  <= 1'b1;
              wvalid   <= 1'b1;
              lsu_busy <= 1'b1;
            end else begin
              state_q  <= StAr;
              araddr   <= lsu_addr;
              arvalid  <= 1'b1;
              lsu_busy <= 1'b1;
            end
          end
        end
        StAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StR;
          end
        end
        StR: begin
          if (rvalid) begin
            rready    <= 1'b0;
            lsu_rdata <= (rresp == RespOkay) ? load_data : 32'h0;
            if (rresp != RespOkay) lsu_err <= ErrBus;
            lsu_valid <= 1'b1;
            lsu_busy  <= 1'b0;
            state_q   <= StDone;
          end
        end
        StWr: begin
          if (aw_fire) awvalid <= 1'b0;
          if (w_fire) wvalid <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            bready  <= 1'b1;
            state_q <= StB;
          end
        end
        StB: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != RespOkay) lsu_err <= ErrBus;
            lsu_valid <= 1'b1;
            lsu_busy  <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
